// File: rtl/cpu_confreg.sv
// Memory-mapped config block: CTRL/TIMER/COMPARE/STATUS timer, LED and switch registers.
// Optional timer prescaler enabled by defining CONFREG_PRESCALE_EN.
module cpu_confreg #(
  parameter logic [31:0] BASE_ADDR = 32'hBFAF_0000,
  parameter logic [15:0] PRESCALE  = 16'd1,
  parameter int          LED_W     = 16,
  parameter int          SW_W      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_wen,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  input  logic [SW_W-1:0]  switch_in,
  output logic [LED_W-1:0] led_out,
  output logic             timer_irq
);

  localparam logic [31:0] LED_MASK = (LED_W >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'h1 << LED_W) - 32'h1);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  logic        sel, wr_en, rd_en;
  logic [15:0] off;
  logic        wr_ctrl, wr_timer, wr_cmp, wr_status, wr_led;
  logic [31:0] ctrl_q, timer_q, cmp_q, led_q;
  logic        pending_q;
  logic        tick, match, clr;
  logic [31:0] timer_tick, rd_val;
  logic        unused_ok;

  assign sel   = data_sram_en && (data_sram_addr[31:16] == BASE_ADDR[31:16]);
  assign off   = {data_sram_addr[15:2], 2'b00};
  assign wr_en = sel && (data_sram_wen != 4'b0000);
  assign rd_en = sel && (data_sram_wen == 4'b0000);

  assign wr_ctrl   = wr_en && (off == 16'h0000);
  assign wr_timer  = wr_en && (off == 16'h0004);
  assign wr_cmp    = wr_en && (off == 16'h0008);
  assign wr_status = wr_en && (off == 16'h000C);
  assign wr_led    = wr_en && (off == 16'hF000);

`ifdef CONFREG_PRESCALE_EN
  logic [15:0] psc_q;
  logic        psc_last;
  assign psc_last = (psc_q == PRESCALE - 16'd1);
  assign tick     = ctrl_q[0] && psc_last;

  // A CTRL write restarts the tick phase so software sees a full period.
  always_ff @(posedge clk) begin
    if (!resetn)                               psc_q <= '0;
    else if (wr_ctrl || !ctrl_q[0] || psc_last) psc_q <= '0;
    else                                       psc_q <= psc_q + 16'd1;
  end
`else
  assign tick = ctrl_q[0];
`endif

  // Match uses the pre-write count; software bytes then override the tick result.
  assign match      = tick && (timer_q == cmp_q);
  assign timer_tick = (match && ctrl_q[1]) ? 32'h0 : (tick ? timer_q + 32'h1 : timer_q);
  assign clr        = wr_status && data_sram_wen[0] && data_sram_wdata[0];
  assign timer_irq  = pending_q && ctrl_q[2];
  assign led_out    = led_q[LED_W-1:0];

  always_comb begin
    rd_val = '0;
    case (off)
      16'h0000: rd_val = ctrl_q;
      16'h0004: rd_val = timer_q;
      16'h0008: rd_val = cmp_q;
      16'h000C: rd_val = {31'h0, pending_q};
      16'hF000: rd_val = led_q;
      16'hF020: rd_val = 32'(switch_in);
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q          <= '0;
      timer_q         <= '0;
      cmp_q           <= '0;
      pending_q       <= 1'b0;
      led_q           <= '0;
      data_sram_rdata <= '0;
    end else begin
      if (wr_ctrl) ctrl_q <= merge(ctrl_q, data_sram_wdata, data_sram_wen) & 32'h7;
      if (wr_cmp)  cmp_q  <= merge(cmp_q, data_sram_wdata, data_sram_wen);
      if (wr_led)  led_q  <= merge(led_q, data_sram_wdata, data_sram_wen) & LED_MASK;
      timer_q   <= wr_timer ? merge(timer_tick, data_sram_wdata, data_sram_wen) : timer_tick;
      pending_q <= match || (pending_q && !clr);
      if (rd_en) data_sram_rdata <= rd_val;
    end
  end

  assign unused_ok = ^{data_sram_addr[1:0], PRESCALE};

endmodule
